imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_loader.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction store loader: receives a program as a byte stream, assembles
// big-endian 32-bit words, writes them into a DEPTH-word store and releases
// the processor (cpu_run) once a complete, well-formed program is loaded.
// The processor reads the same store through a combinational fetch port.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       instruction,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   load_count
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   clr_idx_reg, clr_idx_next;
  logic [1:0]          byte_cnt_reg, byte_cnt_next;
  logic [23:0]         asm_reg, asm_next;
  logic [CW-1:0]       n_reg, n_next;
  logic [CW-1:0]       load_count_reg, load_count_next;
  logic [CW-1:0]       load_count_inc;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [31:0]         wr_data;
  logic                xfer;
  logic                hdr_bad;

  logic [31:0]         mem [DEPTH];

  assign xfer           = byte_valid && byte_ready;
  assign load_count_inc = load_count_reg + CW'(1);
  // A zero-length program or one larger than the store is rejected.
  assign hdr_bad        = (byte_data == 8'd0) || (32'(byte_data) > 32'(DEPTH));
  assign load_count     = load_count_reg;

  // State and datapath registers; the store itself is not touched by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      clr_idx_reg    <= '0;
      byte_cnt_reg   <= '0;
      asm_reg        <= '0;
      n_reg          <= '0;
      load_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      clr_idx_reg    <= clr_idx_next;
      byte_cnt_reg   <= byte_cnt_next;
      asm_reg        <= asm_next;
      n_reg          <= n_next;
      load_count_reg <= load_count_next;
    end
  end

  // Next-state, datapath updates, store write request and status outputs.
  always_comb begin
    state_next      = state_reg;
    clr_idx_next    = clr_idx_reg;
    byte_cnt_next   = byte_cnt_reg;
    asm_next        = asm_reg;
    n_next          = n_reg;
    load_count_next = load_count_reg;
    wr_en           = 1'b0;
    wr_addr         = clr_idx_reg;
    wr_data         = 32'd0;
    byte_ready      = 1'b0;
    busy            = 1'b0;
    cpu_run         = 1'b0;
    error           = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next      = S_CLEAR;
          clr_idx_next    = '0;
          load_count_next = '0;
        end
      end

      S_CLEAR: begin
        // Zero one word per cycle so words beyond N read back as nops.
        busy         = 1'b1;
        wr_en        = 1'b1;
        wr_addr      = clr_idx_reg;
        wr_data      = 32'd0;
        clr_idx_next = clr_idx_reg + ADDR_W'(1);
        if (clr_idx_reg == ADDR_W'(DEPTH - 1)) begin
          state_next    = S_HDR;
          byte_cnt_next = '0;
        end
      end

      S_HDR: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (xfer) begin
          if (hdr_bad) begin
            state_next = S_ERR;
          end else begin
            n_next        = CW'(byte_data);
            byte_cnt_next = '0;
            state_next    = S_DATA;
          end
        end
      end

      S_DATA: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (xfer) begin
          asm_next      = {asm_reg[15:0], byte_data};
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            // Fourth byte completes the word; write it on this same edge.
            wr_en           = 1'b1;
            wr_addr         = load_count_reg[ADDR_W-1:0];
            wr_data         = {asm_reg, byte_data};
            load_count_next = load_count_inc;
            if (load_count_inc == n_reg) begin
              state_next = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        cpu_run = 1'b1;
        if (start) begin
          state_next      = S_CLEAR;
          clr_idx_next    = '0;
          load_count_next = '0;
        end
      end

      S_ERR: begin
        error = 1'b1;
        if (start) begin
          state_next      = S_CLEAR;
          clr_idx_next    = '0;
          load_count_next = '0;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Store write port; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Fetch port: only live while the processor is released and in range.
  assign instruction = (cpu_run && (fetch_addr < 32'(DEPTH)))
                       ? mem[fetch_addr[ADDR_W-1:0]] : 32'd0;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: scenario tasks with randomized programs and gaps,
// checked against a program-level model of the instruction store.
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic [31:0]       fetch_addr = 32'd0;
  logic [31:0]       instruction;
  logic              cpu_run;
  logic              busy;
  logic              error;
  logic [ADDR_W:0]   load_count;

  int checks = 0;
  int errors = 0;

  // Model: what the store should hold and whether the processor is released.
  logic [31:0] model_mem [DEPTH];
  bit          model_run = 1'b0;

  logic [31:0] prog1 [8] = '{32'h00004820, 32'h8f8a0004, 32'h8f8b0008, 32'h012a4820,
                            32'h216bffff, 32'h11600001, 32'h1000fffc, 32'haf890000};

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .fetch_addr(fetch_addr),
    .instruction(instruction), .cpu_run(cpu_run), .busy(busy), .error(error),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    if (model_run && a < DEPTH) return model_mem[a[ADDR_W-1:0]];
    return 32'd0;
  endfunction

  // A successful load leaves the program followed by zeros.
  task automatic model_load(input logic [31:0] w[$]);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = (i < w.size()) ? w[i] : 32'd0;
    model_run = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_run = 1'b0;
  endtask

  task automatic wait_hdr(output int cycles);
    cycles = 0;
    while (byte_ready !== 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) @(negedge clk);
    t = 0;
    while (byte_ready !== 1'b1 && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t == 100) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout byte_ready=%b required 1", byte_ready);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], max_gap);
  endtask

  task automatic do_load(input logic [31:0] w[$], input int max_gap);
    int c;
    pulse_start();
    wait_hdr(c);
    send_byte(8'(w.size()), max_gap);
    foreach (w[i]) send_word(w[i], max_gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    fetch_addr = 32'd0;
    #1;
    checks++;
    if ({byte_ready, cpu_run, busy, error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {byte_ready, cpu_run, busy, error});
    end
    checks++;
    if (load_count !== '0) begin
      errors++;
      $display("FAIL reset_load_count got=%0d exp=0", load_count);
    end
    checks++;
    if (instruction !== 32'd0) begin
      errors++;
      $display("FAIL reset_instruction got=%h exp=0", instruction);
    end
    rst_n = 1'b1;
    // Bytes offered while idle must be ignored.
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = 8'h08;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_ready, busy, load_count} !== '0) begin
      errors++;
      $display("FAIL idle_ignores_bytes got ready=%b busy=%b lc=%0d exp 0/0/0", byte_ready, busy, load_count);
    end
    byte_valid = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic_load();
    int c;
    logic [31:0] q[$];
    logic [31:0] word;
    pulse_start();
    wait_hdr(c);
    checks++;
    if (c != 32) begin
      errors++;
      $display("FAIL basic_clear_cycles got=%0d exp=32", c);
    end
    send_byte(8'h08, 0);
    for (int k = 0; k < 32; k++) begin
      word = prog1[k/4];
      if (k == 31) begin
        checks++;
        if (cpu_run !== 1'b0) begin
          errors++;
          $display("FAIL basic_run_early got=%b exp=0", cpu_run);
        end
      end
      send_byte(word[8*(3-(k%4)) +: 8], 0);
      checks++;
      if (load_count !== 6'((k+1)/4)) begin
        errors++;
        $display("FAIL basic_load_count byte %0d got=%0d exp=%0d", k, load_count, (k+1)/4);
      end
    end
    checks++;
    if ({cpu_run, busy, byte_ready, error} !== 4'b1000) begin
      errors++;
      $display("FAIL basic_done_flags got=%b exp=1000", {cpu_run, busy, byte_ready, error});
    end
    foreach (prog1[i]) q.push_back(prog1[i]);
    model_load(q);
    fetch_addr = 32'd3; #1;
    checks++;
    if (instruction !== 32'h012a4820) begin
      errors++;
      $display("FAIL basic_fetch3 got=%h exp=012a4820", instruction);
    end
    fetch_addr = 32'd7; #1;
    checks++;
    if (instruction !== 32'haf890000) begin
      errors++;
      $display("FAIL basic_fetch7 got=%h exp=af890000", instruction);
    end
    fetch_addr = 32'd8; #1;
    checks++;
    if (instruction !== 32'd0) begin
      errors++;
      $display("FAIL basic_fetch8 got=%h exp=0", instruction);
    end
    fetch_addr = 32'd40; #1;
    checks++;
    if (instruction !== 32'd0) begin
      errors++;
      $display("FAIL basic_fetch40 got=%h exp=0", instruction);
    end
    fetch_addr = 32'h8000_0003; #1;
    checks++;
    if (instruction !== 32'd0) begin
      errors++;
      $display("FAIL basic_fetch_high got=%h exp=0", instruction);
    end
    for (int a = 0; a < DEPTH; a++) begin
      fetch_addr = 32'(a); #1;
      checks++;
      if (instruction !== exp_instr(32'(a))) begin
        errors++;
        $display("FAIL basic_store[%0d] got=%h exp=%h", a, instruction, exp_instr(32'(a)));
      end
    end
    $display("test_basic_load done: load_count=%0d", load_count);
  endtask

  task automatic test_reload_fewer();
    logic [31:0] q[$];
    q = '{32'h20080005};
    pulse_start();
    // Reload begins: processor is stalled immediately.
    checks++;
    if ({cpu_run, busy, load_count} !== {1'b0, 1'b1, 6'd0}) begin
      errors++;
      $display("FAIL reload_entry got run=%b busy=%b lc=%0d exp 0/1/0", cpu_run, busy, load_count);
    end
    repeat (33) @(negedge clk);
    send_byte(8'h01, 0);
    send_word(32'h20080005, 0);
    model_load(q);
    checks++;
    if ({cpu_run, load_count} !== {1'b1, 6'd1}) begin
      errors++;
      $display("FAIL reload_done got run=%b lc=%0d exp 1/1", cpu_run, load_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      fetch_addr = 32'(a); #1;
      checks++;
      if (instruction !== exp_instr(32'(a))) begin
        errors++;
        $display("FAIL reload_store[%0d] got=%h exp=%h", a, instruction, exp_instr(32'(a)));
      end
    end
    $display("test_reload_fewer done");
  endtask

  task automatic test_backpressure();
    int c;
    int gap;
    logic [31:0] q[$];
    logic [31:0] word;
    pulse_start();
    wait_hdr(c);
    send_byte(8'h08, 2);
    for (int k = 0; k < 32; k++) begin
      gap = int'($urandom_range(2, 0));
      repeat (gap) begin
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_in_gap byte %0d got=%b exp=1", k, byte_ready);
        end
      end
      word = prog1[k/4];
      send_byte(word[8*(3-(k%4)) +: 8], 0);
    end
    foreach (prog1[i]) q.push_back(prog1[i]);
    model_load(q);
    checks++;
    if ({cpu_run, load_count} !== {1'b1, 6'd8}) begin
      errors++;
      $display("FAIL bp_done got run=%b lc=%0d exp 1/8", cpu_run, load_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      fetch_addr = 32'(a); #1;
      checks++;
      if (instruction !== exp_instr(32'(a))) begin
        errors++;
        $display("FAIL bp_store[%0d] got=%h exp=%h", a, instruction, exp_instr(32'(a)));
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_bad_header();
    int c;
    logic [7:0] bad [3] = '{8'h00, 8'h21, 8'hff};
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      checks++;
      if ({error, busy} !== 2'b01) begin
        errors++;
        $display("FAIL bad_hdr_start_clears hdr=%h got err=%b busy=%b exp 0/1", bad[i], error, busy);
      end
      wait_hdr(c);
      checks++;
      if (c != 32) begin
        errors++;
        $display("FAIL bad_hdr_clear_cycles hdr=%h got=%0d exp=32", bad[i], c);
      end
      send_byte(bad[i], 0);
      checks++;
      if ({error, cpu_run, byte_ready, busy} !== 4'b1000) begin
        errors++;
        $display("FAIL bad_hdr_flags hdr=%h got=%b exp=1000", bad[i], {error, cpu_run, byte_ready, busy});
      end
      for (int a = 0; a < 8; a++) begin
        fetch_addr = 32'($urandom_range(40, 0)); #1;
        checks++;
        if (instruction !== 32'd0) begin
          errors++;
          $display("FAIL bad_hdr_fetch addr=%0d got=%h exp=0", fetch_addr, instruction);
        end
      end
    end
    $display("test_bad_header done");
  endtask

  task automatic test_start_ignored();
    int c;
    logic [31:0] q[$];
    logic [31:0] word;
    for (int i = 0; i < 8; i++) q.push_back($urandom);
    pulse_start();
    wait_hdr(c);
    send_byte(8'h08, 0);
    for (int k = 0; k < 32; k++) begin
      word = q[k/4];
      send_byte(word[8*(3-(k%4)) +: 8], 1);
      if (k == 4) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, byte_ready, load_count} !== {1'b1, 1'b1, 6'd1}) begin
          errors++;
          $display("FAIL start_ignored_mid got busy=%b ready=%b lc=%0d exp 1/1/1", busy, byte_ready, load_count);
        end
      end
    end
    model_load(q);
    checks++;
    if ({cpu_run, load_count} !== {1'b1, 6'd8}) begin
      errors++;
      $display("FAIL start_ignored_done got run=%b lc=%0d exp 1/8", cpu_run, load_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      fetch_addr = 32'(a); #1;
      checks++;
      if (instruction !== exp_instr(32'(a))) begin
        errors++;
        $display("FAIL start_ignored_store[%0d] got=%h exp=%h", a, instruction, exp_instr(32'(a)));
      end
    end
    $display("test_start_ignored done");
  endtask

  task automatic test_random_loads();
    logic [31:0] q[$];
    int n;
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? DEPTH : int'($urandom_range(DEPTH, 1));
      q.delete();
      for (int i = 0; i < n; i++) q.push_back($urandom);
      do_load(q, 2);
      model_load(q);
      checks++;
      if ({cpu_run, load_count} !== {1'b1, 6'(n)}) begin
        errors++;
        $display("FAIL rand_done n=%0d got run=%b lc=%0d exp 1/%0d", n, cpu_run, load_count, n);
      end
      for (int a = 0; a < DEPTH + 4; a++) begin
        fetch_addr = 32'(a); #1;
        checks++;
        if (instruction !== exp_instr(32'(a))) begin
          errors++;
          $display("FAIL rand_store n=%0d [%0d] got=%h exp=%h", n, a, instruction, exp_instr(32'(a)));
        end
      end
      $display("test_random_loads: load of %0d words done", n);
    end
  endtask

  task automatic test_reset_mid_load();
    int c;
    logic [31:0] q[$];
    logic [31:0] word;
    for (int i = 0; i < 8; i++) q.push_back($urandom);
    pulse_start();
    wait_hdr(c);
    send_byte(8'h08, 0);
    for (int k = 0; k < 10; k++) begin
      word = q[k/4];
      send_byte(word[8*(3-(k%4)) +: 8], 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_run = 1'b0;
    fetch_addr = 32'd0; #1;
    checks++;
    if ({byte_ready, cpu_run, busy, error, load_count, instruction} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got ready=%b run=%b busy=%b err=%b lc=%0d instr=%h exp all 0",
               byte_ready, cpu_run, busy, error, load_count, instruction);
    end
    q.delete();
    q.push_back($urandom);
    q.push_back($urandom);
    do_load(q, 1);
    model_load(q);
    checks++;
    if ({cpu_run, load_count} !== {1'b1, 6'd2}) begin
      errors++;
      $display("FAIL mid_reset_reload got run=%b lc=%0d exp 1/2", cpu_run, load_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      fetch_addr = 32'(a); #1;
      checks++;
      if (instruction !== exp_instr(32'(a))) begin
        errors++;
        $display("FAIL mid_reset_store[%0d] got=%h exp=%h", a, instruction, exp_instr(32'(a)));
      end
    end
    $display("test_reset_mid_load done");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    test_reset();
    test_basic_load();
    test_reload_fewer();
    test_backpressure();
    test_start_ignored();
    test_bad_header();
    test_random_loads();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
